// File: rtl/hsv_core_pkg.sv
// Shared types for the core memory unit.
//   mem_counter       : wide enough to hold 0..max(MEM_MAX_READS, MEM_MAX_WRITES)
//   word              : 32-bit data/address word
//   txn_fence_state_t : fence drain FSM states of the transaction tracker
package hsv_core_pkg;

   localparam int MEM_MAX_READS  = 8;
   localparam int MEM_MAX_WRITES = 8;
   localparam int MEM_MAX_TXNS   = (MEM_MAX_READS > MEM_MAX_WRITES) ? MEM_MAX_READS : MEM_MAX_WRITES;
   localparam int MEM_COUNTER_W  = $clog2(MEM_MAX_TXNS + 1);

   typedef logic [MEM_COUNTER_W-1:0] mem_counter;
   typedef logic [31:0]              word;

   typedef enum logic {
      TXN_IDLE,
      TXN_DRAIN
   } txn_fence_state_t;

endpackage

// File: rtl/hsv_core_mem_addr_fifo.sv
// In-order address FIFO with a combinational head read.
//   clk_core, rst_core_n : clock, asynchronous active-low reset (pointers only)
//   push, push_data      : enqueue push_data (ignored when full)
//   pop                  : dequeue the head (ignored when empty)
//   head                 : oldest entry, don't-care when empty
//   full, empty          : occupancy flags
module hsv_core_mem_addr_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32
) (
   input  logic             clk_core,
   input  logic             rst_core_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   // One extra pointer bit separates "full" from "empty" when the indices match.
   logic [AW:0]      rd_ptr;
   logic [AW:0]      wr_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign full    = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);
   assign empty   = (rd_ptr == wr_ptr);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_core or negedge rst_core_n) begin
      if (!rst_core_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage carries no reset; only the pointers define validity.
   always_ff @(posedge clk_core) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/hsv_core_mem_txn_tracker.sv
// Outstanding AXI transaction tracker for the data-memory unit.
//   Issue side     : issue_read/issue_write(+address), can_issue_read/can_issue_write
//   Completion side: pending_reads_down/pending_writes_down, pending_reads/pending_writes,
//                    pending_write_completed_address (address of the next B response)
//   Fence          : fence_request in, fence_valid out while draining, fence_ready to leave
//   Debug          : underflow_error, sticky until reset
//   flush only returns the fence FSM to IDLE; responses still owed keep being counted.
module hsv_core_mem_txn_tracker
   import hsv_core_pkg::*;
#(
   parameter int MAX_READS  = MEM_MAX_READS,
   parameter int MAX_WRITES = MEM_MAX_WRITES
) (
   input  logic       clk_core,
   input  logic       rst_core_n,
   input  logic       flush,
   input  logic       issue_read,
   input  logic       issue_write,
   input  word        issue_write_address,
   output logic       can_issue_read,
   output logic       can_issue_write,
   input  logic       pending_reads_down,
   input  logic       pending_writes_down,
   output mem_counter pending_reads,
   output mem_counter pending_writes,
   output word        pending_write_completed_address,
   input  logic       fence_request,
   output logic       fence_valid,
   input  logic       fence_ready,
   output logic       underflow_error
);

   localparam mem_counter RD_FULL = mem_counter'(MAX_READS);
   localparam mem_counter WR_FULL = mem_counter'(MAX_WRITES);

   txn_fence_state_t state, state_nxt;

   logic       rd_up, rd_dn, wr_up, wr_dn;
   logic       underflow_evt;
   mem_counter pending_reads_nxt, pending_writes_nxt;
   logic       fifo_full, fifo_empty;

   // Overflowing issues and down events at zero are dropped here, so the
   // counters saturate and the FIFO never sees an illegal push or pop.
   assign rd_up         = issue_read  & (pending_reads  != RD_FULL);
   assign wr_up         = issue_write & (pending_writes != WR_FULL);
   assign rd_dn         = pending_reads_down  & (pending_reads  != '0);
   assign wr_dn         = pending_writes_down & (pending_writes != '0);
   assign underflow_evt = (pending_reads_down  & (pending_reads  == '0))
                        | (pending_writes_down & (pending_writes == '0));

   always_comb begin
      pending_reads_nxt  = pending_reads  + mem_counter'(rd_up) - mem_counter'(rd_dn);
      pending_writes_nxt = pending_writes + mem_counter'(wr_up) - mem_counter'(wr_dn);
   end

   always_ff @(posedge clk_core or negedge rst_core_n) begin
      if (!rst_core_n) begin
         pending_reads   <= '0;
         pending_writes  <= '0;
         underflow_error <= 1'b0;
      end else begin
         pending_reads  <= pending_reads_nxt;
         pending_writes <= pending_writes_nxt;
         if (underflow_evt) underflow_error <= 1'b1;
      end
   end

   // Issue gating uses the registered count only: a full counter draining this
   // cycle reopens issue next cycle.
   assign can_issue_read  = (pending_reads  != RD_FULL) & (state == TXN_IDLE) & ~fence_request;
   assign can_issue_write = (pending_writes != WR_FULL) & (state == TXN_IDLE) & ~fence_request;

   hsv_core_mem_addr_fifo #(
      .DEPTH (MAX_WRITES),
      .WIDTH ($bits(word))
   ) u_wr_addr_fifo (
      .clk_core   (clk_core),
      .rst_core_n (rst_core_n),
      .push       (wr_up),
      .push_data  (issue_write_address),
      .pop        (wr_dn),
      .head       (pending_write_completed_address),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

   // Fence FSM: state register
   always_ff @(posedge clk_core or negedge rst_core_n) begin
      if (!rst_core_n) state <= TXN_IDLE;
      else             state <= state_nxt;
   end

   // Fence FSM: next state; flush always abandons a drain
   always_comb begin
      state_nxt = state;
      unique case (state)
         TXN_IDLE:  if (fence_request & ~flush) state_nxt = TXN_DRAIN;
         TXN_DRAIN: if (fence_ready | flush)    state_nxt = TXN_IDLE;
         default:                               state_nxt = TXN_IDLE;
      endcase
   end

   // Fence FSM: outputs
   always_comb begin
      fence_valid = (state == TXN_DRAIN);
   end

   // The request stage must never fire an issue at capacity.
   a_no_read_overflow: assert property (@(posedge clk_core) disable iff (!rst_core_n)
      !(issue_read && pending_reads == RD_FULL));
   a_no_write_overflow: assert property (@(posedge clk_core) disable iff (!rst_core_n)
      !(issue_write && pending_writes == WR_FULL));
   // FIFO occupancy tracks the write counter exactly.
   a_fifo_tracks_count: assert property (@(posedge clk_core) disable iff (!rst_core_n)
      (fifo_empty == (pending_writes == '0)) && (fifo_full == (pending_writes == WR_FULL)));

endmodule
